pixie_video_out: RTL and testbench
==================================

PIXIE_VIDEO_OUT -- requirements
Module: pixie_video_out

Interface
REQ-001 Parameter VSYNC_MIN, default 32: csync-low width in ce ticks at or above which the pulse is a vertical sync.
REQ-002 Parameter H_START, default 40: h_cnt value at which active video begins.
REQ-003 Parameter H_LEN, default 128: active pixels per line.
REQ-004 Parameter V_START, default 16: v_cnt value at which active lines begin.
REQ-005 Parameter V_LEN, default 128: active lines per frame.
REQ-006 Parameter FG_COLOR, default 8'hFF: level driven on r/g/b for a lit pixel.
REQ-007 Ports: clk in 1, the video clock; one clock domain only.
REQ-008 Ports: reset in 1, synchronous, active-high.
REQ-009 Ports: ce_pix in 1, pixel-rate enable; all state advances only when ce_pix=1.
REQ-010 Ports: csync in 1, composite sync from the Pixie back end, active-low.
REQ-011 Ports: video in 1, pixel data from the Pixie back end.
REQ-012 Ports: hsync out 1, hblank out 1, vsync out 1, vblank out 1; all active-high.
REQ-013 Ports: r, g, b out 8 each.
REQ-014 Ports: de out 1, which is ~hblank & ~vblank.
REQ-015 Ports: locked out 1, stable frame geometry detected.

Function
REQ-016 Every register updates only on ce_pix=1; with ce_pix=0 all outputs hold.
REQ-017 Edge detect: prev_csync is registered each tick; fall = prev&~csync and rise = ~prev&csync.
REQ-018 low_cnt (8 bit) clears on fall, increments while csync=0, and saturates at 255.
REQ-019 h_cnt (10 bit) clears to 0 on fall, otherwise increments and saturates at 1023.
REQ-020 hsync = registered ~csync, giving 1-tick latency.
REQ-021 vsync rises on the tick low_cnt reaches VSYNC_MIN-1 with csync=0, and falls on rise.
REQ-022 Sync class FSM has states IDLE, HLOW, VLOW.
REQ-023 FSM IDLE: fall -> HLOW.
REQ-024 FSM HLOW: low_cnt = VSYNC_MIN-1 -> VLOW; rise -> IDLE.
REQ-025 FSM VLOW: rise -> IDLE and end-of-frame event.
REQ-026 v_cnt (9 bit) increments on each fall from IDLE, saturates at 511, and clears to 0 on end-of-frame.
REQ-027 hblank = 0 iff H_START <= h_cnt < H_START+H_LEN; the comparison is registered, 1-tick latency.
REQ-028 vblank = 0 iff V_START <= v_cnt < V_START+V_LEN; the comparison is registered.
REQ-029 r=g=b = FG_COLOR when de=1 and video=1 (video sampled the same tick as the h_cnt compare), else 8'h00.
REQ-030 Lock: at end-of-frame, v_cnt is compared with last_lines (9 bit); match -> lock_cnt++ saturating at 3, mismatch -> lock_cnt=0; last_lines <= v_cnt.
REQ-031 locked = 1 iff lock_cnt >= 2.
REQ-032 Fall coincident with a vsync already in progress (VLOW) is impossible by construction; csync staying low counts only once.
REQ-033 A glitch low pulse of 1 tick is a valid hsync: it clears h_cnt and increments v_cnt.
REQ-034 If csync is stuck high, h_cnt saturates at 1023, hblank = 1, and locked holds its value.

Reset
REQ-035 Reset (ce_pix ignored) sets FSM=IDLE, prev_csync=1, low_cnt=0, h_cnt=1023, v_cnt=511, last_lines=0, lock_cnt=0.
REQ-036 Reset values of outputs: hsync=0, vsync=0, hblank=1, vblank=1, de=0, r=g=b=0, locked=0.
REQ-037 Reset asserted mid-line or mid-vsync returns to IDLE; the first fall after release starts a new line.

Verification
REQ-038 Scenario: reset for 3 clk with ce_pix=1 -> all outputs at REQ-035/036 values; video=1 still gives r=0.
REQ-039 Scenario: 8-tick csync low pulse -> hsync high 8 ticks delayed by 1, vsync stays 0, h_cnt=0 after fall, v_cnt+1.
REQ-040 Scenario: 40-tick csync low -> vsync rises 31 ticks after fall, falls 1 tick after rise; v_cnt=0 afterward.
REQ-041 Scenario: video=1 with v_cnt=16 -> de=1 and r=g=b=8'hFF exactly for h_cnt 40..167 (128 ticks, 1-tick offset); v_cnt=15 -> de=0, rgb=0.
REQ-042 Scenario: three frames of 262 lines -> locked=1 after the third vsync; then one 200-line frame -> locked=0.
REQ-043 Scenario: ce_pix held 0 for 10 clk mid-line with csync toggling -> no counter or output change.

Source files
------------

// File: rtl/pixie_video_out.sv
// rtl/pixie_video_out.sv - Pixie composite-sync decoder: h/v sync, blanking, pixel colour and frame lock
module pixie_video_out #(
  parameter int         VSYNC_MIN = 32,
  parameter int         H_START   = 40,
  parameter int         H_LEN     = 128,
  parameter int         V_START   = 16,
  parameter int         V_LEN     = 128,
  parameter logic [7:0] FG_COLOR  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       csync,
  input  logic       video,
  output logic       hsync,
  output logic       hblank,
  output logic       vsync,
  output logic       vblank,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       de,
  output logic       locked
);

  localparam logic [7:0] VS_TH = 8'(VSYNC_MIN - 1);
  localparam int         H_END = H_START + H_LEN;
  localparam int         V_END = V_START + V_LEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HLOW,
    S_VLOW
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       prev_csync;
  logic [7:0] low_cnt;
  logic [7:0] low_cnt_next;
  logic [9:0] h_cnt;
  logic [8:0] v_cnt;
  logic [8:0] last_lines;
  logic [1:0] lock_cnt;
  logic       pix_on;
  logic       fall;
  logic       rise;
  logic       vs_hit;
  logic       eof;
  logic       line_start;
  logic       h_in;
  logic       v_in;

  // csync edges relative to the previous ce tick's sample
  assign fall = prev_csync & ~csync;
  assign rise = ~prev_csync & csync;

  // Length of the current low run; 0 on the falling tick, saturating at 255
  always_comb begin
    low_cnt_next = low_cnt;
    if (fall) begin
      low_cnt_next = 8'd0;
    end else if (!csync && low_cnt != 8'hFF) begin
      low_cnt_next = low_cnt + 8'd1;
    end
  end

  // A low run turns into a vertical sync on the tick its length reaches the threshold
  assign vs_hit = (state == S_HLOW) && !csync && (low_cnt_next == VS_TH);

  // Sync classifier state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (ce_pix) begin
      state <= state_next;
    end
  end

  // Sync classifier next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (fall) state_next = S_HLOW;
      S_HLOW: begin
        if (vs_hit) begin
          state_next = S_VLOW;
        end else if (rise) begin
          state_next = S_IDLE;
        end
      end
      S_VLOW: if (rise) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Sync classifier events: start of a line and end of a frame
  always_comb begin
    line_start = 1'b0;
    eof        = 1'b0;
    case (state)
      S_IDLE:  line_start = fall;
      S_VLOW:  eof        = rise;
      default: ;
    endcase
  end

  // Edge history, low-run counter and the sync outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_csync <= 1'b1;
      low_cnt    <= 8'd0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
    end else if (ce_pix) begin
      prev_csync <= csync;
      low_cnt    <= low_cnt_next;
      hsync      <= ~csync;
      if (vs_hit) begin
        vsync <= 1'b1;
      end else if (rise) begin
        vsync <= 1'b0;
      end
    end
  end

  // Horizontal position within the line and line number within the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= 10'h3FF;
      v_cnt <= 9'h1FF;
    end else if (ce_pix) begin
      if (fall) begin
        h_cnt <= 10'd0;
      end else if (h_cnt != 10'h3FF) begin
        h_cnt <= h_cnt + 10'd1;
      end
      if (eof) begin
        v_cnt <= 9'd0;
      end else if (line_start && v_cnt != 9'h1FF) begin
        v_cnt <= v_cnt + 9'd1;
      end
    end
  end

  assign h_in = (int'(h_cnt) >= H_START) && (int'(h_cnt) < H_END);
  assign v_in = (int'(v_cnt) >= V_START) && (int'(v_cnt) < V_END);

  // Registered active-window decode; video is captured alongside so colour lines up with de
  always_ff @(posedge clk) begin
    if (reset) begin
      hblank <= 1'b1;
      vblank <= 1'b1;
      pix_on <= 1'b0;
    end else if (ce_pix) begin
      hblank <= ~h_in;
      vblank <= ~v_in;
      pix_on <= h_in & v_in & video;
    end
  end

  // Frame lock: count consecutive frames with identical line counts
  always_ff @(posedge clk) begin
    if (reset) begin
      last_lines <= 9'd0;
      lock_cnt   <= 2'd0;
    end else if (ce_pix && eof) begin
      if (v_cnt == last_lines) begin
        if (lock_cnt != 2'd3) begin
          lock_cnt <= lock_cnt + 2'd1;
        end
      end else begin
        lock_cnt <= 2'd0;
      end
      last_lines <= v_cnt;
    end
  end

  assign de     = ~hblank & ~vblank;
  assign r      = pix_on ? FG_COLOR : 8'h00;
  assign g      = pix_on ? FG_COLOR : 8'h00;
  assign b      = pix_on ? FG_COLOR : 8'h00;
  assign locked = lock_cnt[1];

endmodule

// File: tb/tb_pixie_video_out.sv
// tb/tb_pixie_video_out.sv - scoreboard bench for pixie_video_out
module tb_pixie_video_out;

  localparam int         VSYNC_MIN = 32;
  localparam int         H_START   = 40;
  localparam int         H_LEN     = 128;
  localparam int         V_START   = 16;
  localparam int         V_LEN     = 128;
  localparam logic [7:0] FG_COLOR  = 8'hFF;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        hblank;
    logic        vblank;
    logic        de;
    logic [23:0] rgb;
    logic        locked;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic       csync = 1'b1;
  logic       video = 1'b0;
  logic       hsync, hblank, vsync, vblank, de, locked;
  logic [7:0] r, g, b;

  int errors = 0;
  int checks = 0;
  obs_t exp_q[$];

  // reference model: run lengths and line/frame counts
  bit m_prev = 1'b1;
  int m_h = 1023;
  int m_lines = 511;
  int m_low_len = 0;
  bit m_is_v = 1'b0;
  int m_last = 0;
  int m_match = 0;
  bit m_hsync, m_vsync, m_hblank, m_vblank, m_pix;

  pixie_video_out #(
    .VSYNC_MIN(VSYNC_MIN), .H_START(H_START), .H_LEN(H_LEN),
    .V_START(V_START), .V_LEN(V_LEN), .FG_COLOR(FG_COLOR)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .csync(csync), .video(video),
    .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .r(r), .g(g), .b(b), .de(de), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit rst, input bit ce, input bit c, input bit v);
    bit hwin, vwin;
    if (rst) begin
      m_prev = 1'b1; m_h = 1023; m_lines = 511; m_low_len = 0; m_is_v = 1'b0;
      m_last = 0; m_match = 0;
      m_hsync = 1'b0; m_vsync = 1'b0; m_hblank = 1'b1; m_vblank = 1'b1; m_pix = 1'b0;
    end else if (ce) begin
      hwin = (m_h >= H_START) && (m_h < H_START + H_LEN);
      vwin = (m_lines >= V_START) && (m_lines < V_START + V_LEN);
      m_hblank = !hwin;
      m_vblank = !vwin;
      m_pix = hwin && vwin && v;
      m_hsync = !c;
      if (m_prev && !c) begin
        m_h = 0;
        m_low_len = 1;
        m_lines = (m_lines < 511) ? m_lines + 1 : 511;
      end else begin
        m_h = (m_h < 1023) ? m_h + 1 : 1023;
        if (!c) m_low_len++;
      end
      if (!c && m_low_len == VSYNC_MIN && !m_is_v) begin
        m_vsync = 1'b1;
        m_is_v = 1'b1;
      end
      if (!m_prev && c) begin
        m_vsync = 1'b0;
        if (m_is_v) begin
          if (m_lines == m_last) m_match = (m_match < 3) ? m_match + 1 : 3;
          else m_match = 0;
          m_last = m_lines;
          m_lines = 0;
          m_is_v = 1'b0;
        end
      end
      m_prev = c;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.hsync  = m_hsync;
    o.vsync  = m_vsync;
    o.hblank = m_hblank;
    o.vblank = m_vblank;
    o.de     = !m_hblank && !m_vblank;
    o.rgb    = m_pix ? {FG_COLOR, FG_COLOR, FG_COLOR} : 24'h0;
    o.locked = (m_match >= 2);
    return o;
  endfunction

  // one clock of stimulus; the expected post-edge outputs go to the scoreboard
  task automatic drive(input bit rst, input bit ce, input bit c, input bit v);
    @(negedge clk);
    reset = rst; ce_pix = ce; csync = c; video = v;
    model_step(rst, ce, c, v);
    exp_q.push_back(model_obs());
  endtask

  // n ce ticks at csync level c, optionally with idle clocks (csync scrambled) interleaved
  task automatic run_ticks(input bit c, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 4) == 0) drive(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      drive(1'b0, 1'b1, c, 1'($urandom));
    end
  endtask

  task automatic line(input int low_w, input int high_w, input bit gaps);
    run_ticks(1'b0, low_w, gaps);
    run_ticks(1'b1, high_w, gaps);
  endtask

  task automatic frame(input int lines_n, input bit gaps);
    for (int i = 0; i < lines_n - 1; i++) line($urandom_range(1, 8), 6, gaps);
    line(40, 10, gaps);
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // scoreboard monitor: compare outputs one time unit after every active edge
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{hsync, vsync, hblank, vblank, de, {r, g, b}, locked};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t actual=%h required=%h", $time, a, e);
      end
    end
  end

  initial begin
    // reset with ce_pix=1 and video=1
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    chk("reset_hblank", hblank, 1'b1);
    chk("reset_vblank", vblank, 1'b1);
    chk("reset_rgb_zero", |{r, g, b}, 1'b0);
    chk("reset_locked", locked, 1'b0);

    // open a frame, then full-width lines that cross the active window
    line(40, 20, 1'b0);
    for (int i = 0; i < 20; i++) line(8, 200, 1'b1);

    // clock enable held low mid-line with csync toggling
    run_ticks(1'b1, 30, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    run_ticks(1'b1, 10, 1'b0);

    // single-tick glitch pulses count as lines
    for (int i = 0; i < 3; i++) line(1, 12, 1'b1);

    // vsync threshold boundary: 31 low ticks stays horizontal, 32 goes vertical
    line(4, 6, 1'b0);
    run_ticks(1'b0, 31, 1'b0);
    settle();
    chk("low31_no_vsync", vsync, 1'b0);
    run_ticks(1'b1, 6, 1'b0);
    run_ticks(1'b0, 32, 1'b0);
    settle();
    chk("low32_vsync", vsync, 1'b1);
    run_ticks(1'b1, 1, 1'b0);
    settle();
    chk("vsync_drop_on_rise", vsync, 1'b0);
    run_ticks(1'b1, 5, 1'b0);

    // lock on three identical 262-line frames, lose it on a 200-line frame
    frame(262, 1'b1);
    frame(262, 1'b1);
    settle();
    chk("locked_after_2", locked, 1'b0);
    frame(262, 1'b1);
    settle();
    chk("locked_after_3", locked, 1'b1);
    frame(200, 1'b1);
    settle();
    chk("unlock_200", locked, 1'b0);

    // random lines, pulse widths around the vsync threshold, occasional reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        run_ticks(1'b0, $urandom_range(1, 40), 1'b1);
        drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      case ($urandom_range(0, 9))
        0:       line($urandom_range(30, 34), $urandom_range(1, 20), 1'b1);
        1:       line(1, $urandom_range(1, 4), 1'b1);
        default: line($urandom_range(1, 10), $urandom_range(1, 40), 1'b1);
      endcase
    end

    // csync stuck high: h_cnt saturates and blanking holds
    run_ticks(1'b1, 1100, 1'b1);
    settle();
    chk("stuck_high_hblank", hblank, 1'b1);

    drive(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
